// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 access codes and FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store enables/replication, load extraction/extension,
// and legality/alignment decode of a single access.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] shifted;
    logic        size_misalign;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        be            = 4'b0000;
        wdata         = rs2;
        ld_ext        = '0;
        size_misalign = 1'b0;

        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{rs2[7:0]}};
            end
            2'b01: begin
                be            = 4'b0011 << addr_lo;
                wdata         = {2{rs2[15:0]}};
                size_misalign = addr_lo[0];
            end
            2'b10: begin
                be            = 4'b1111;
                size_misalign = |addr_lo;
            end
            default: ;
        endcase

        case (funct3)
            LB:      ld_ext = {{24{shifted[7]}}, shifted[7:0]};
            LH:      ld_ext = {{16{shifted[15]}}, shifted[15:0]};
            LW:      ld_ext = rdata;
            LBU:     ld_ext = {24'h0, shifted[7:0]};
            LHU:     ld_ext = {16'h0, shifted[15:0]};
            default: ld_ext = '0;
        endcase
    end

    // Stores only have byte/half/word; loads additionally have the unsigned variants.
    assign illegal  = is_load ? (funct3 inside {3'b011, 3'b110, 3'b111}) : (funct3 >= 3'b011);
    assign misalign = size_misalign & ~illegal;

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: accepts one access from decode, runs a single req/ack
// bus transaction, and stalls the core until the DONE cycle.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        store_en,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] data_rs2,
    output logic        stall,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic        misalign,
    output logic        acc_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        ld_valid_q, ld_valid_d;
    logic        misalign_q, misalign_d;
    logic        acc_err_q, acc_err_d;

    logic        idle, access;
    logic        a_is_load, a_misalign, a_illegal;
    logic [2:0]  a_funct3;
    logic [1:0]  a_addr_lo;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_ld_ext;

    assign idle   = (state_q == ST_IDLE);
    assign access = load_en | store_en;

    // In IDLE the aligner decodes the live request; afterwards it works on the latched one.
    assign a_is_load = idle ? load_en     : is_load_q;
    assign a_funct3  = idle ? funct3      : funct3_q;
    assign a_addr_lo = idle ? addr[1:0]   : addr_lo_q;

    lsu_align u_align (
        .is_load  (a_is_load),
        .funct3   (a_funct3),
        .addr_lo  (a_addr_lo),
        .rs2      (data_rs2),
        .rdata    (mem_rdata),
        .be       (a_be),
        .wdata    (a_wdata),
        .ld_ext   (a_ld_ext),
        .misalign (a_misalign),
        .illegal  (a_illegal)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_load_d  = is_load_q;
        funct3_d   = funct3_q;
        addr_lo_d  = addr_lo_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        ld_data_d  = ld_data_q;
        ld_valid_d = 1'b0;
        misalign_d = 1'b0;
        acc_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    is_load_d = load_en;
                    funct3_d  = funct3;
                    addr_lo_d = addr[1:0];
                    if (a_illegal) begin
                        state_d   = ST_DONE;
                        acc_err_d = 1'b1;
                        ld_data_d = '0;
                    end else if (a_misalign) begin
                        state_d    = ST_DONE;
                        misalign_d = 1'b1;
                        ld_data_d  = '0;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = ~load_en;
                        addr_d  = {addr[31:2], 2'b00};
                        be_d    = a_be;
                        wdata_d = a_wdata;
                    end
                end
            end
            ST_BUSY: begin
                // An ack in the final timeout cycle still wins.
                if (mem_ack) begin
                    state_d = ST_DONE;
                    req_d   = 1'b0;
                    if (is_load_q) begin
                        ld_data_d  = a_ld_ext;
                        ld_valid_d = 1'b1;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = ST_DONE;
                    req_d     = 1'b0;
                    acc_err_d = 1'b1;
                    ld_data_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            is_load_q  <= 1'b0;
            funct3_q   <= '0;
            addr_lo_q  <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            ld_data_q  <= '0;
            ld_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            acc_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_load_q  <= is_load_d;
            funct3_q   <= funct3_d;
            addr_lo_q  <= addr_lo_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            misalign_q <= misalign_d;
            acc_err_q  <= acc_err_d;
        end
    end

    assign stall     = rst_n & ((idle & access) | (state_q == ST_BUSY));
    assign ld_valid  = ld_valid_q;
    assign ld_data   = ld_data_q;
    assign misalign  = misalign_q;
    assign acc_err   = acc_err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: table of single-transaction vectors plus hand sequences for
// long acks, bus timeout (separate TIMEOUT=4 instance) and reset mid-access.
`timescale 1ns/1ps
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en, store_en, load_en_t;
    logic [2:0]  funct3;
    logic [31:0] addr, data_rs2, mem_rdata;
    logic        mem_ack, mem_ack_t;

    logic        stall, ld_valid, misalign, acc_err, mem_req, mem_we;
    logic [31:0] ld_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        t_stall, t_ld_valid, t_misalign, t_acc_err, t_mem_req, t_mem_we;
    logic [31:0] t_ld_data, t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .store_en(store_en),
        .funct3(funct3), .addr(addr), .data_rs2(data_rs2), .stall(stall),
        .ld_valid(ld_valid), .ld_data(ld_data), .misalign(misalign), .acc_err(acc_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    lsu #(.TIMEOUT(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .load_en(load_en_t), .store_en(1'b0),
        .funct3(funct3), .addr(addr), .data_rs2(data_rs2), .stall(t_stall),
        .ld_valid(t_ld_valid), .ld_data(t_ld_data), .misalign(t_misalign), .acc_err(t_acc_err),
        .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_be(t_mem_be),
        .mem_wdata(t_mem_wdata), .mem_ack(mem_ack_t), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        ld_valid;
        logic [31:0] ld_data;
        logic        mis;
        logic        err;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        load_en  = v.ld;
        store_en = v.st;
        funct3   = v.f3;
        addr     = v.addr;
        data_rs2 = v.rs2;
        #1;
        check($sformatf("v%0d_accept_stall", idx), 32'(stall), 32'd1);
        tick();
        if (v.mis || v.err) begin
            check($sformatf("v%0d_err_req", idx), 32'(mem_req), 32'd0);
            check($sformatf("v%0d_misalign", idx), 32'(misalign), 32'(v.mis));
            check($sformatf("v%0d_acc_err", idx), 32'(acc_err), 32'(v.err));
            check($sformatf("v%0d_err_ldv", idx), 32'(ld_valid), 32'd0);
            check($sformatf("v%0d_err_stall", idx), 32'(stall), 32'd0);
        end else begin
            check($sformatf("v%0d_req", idx), 32'(mem_req), 32'd1);
            check($sformatf("v%0d_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
            check($sformatf("v%0d_be", idx), 32'(mem_be), 32'(v.be));
            check($sformatf("v%0d_we", idx), 32'(mem_we), 32'(!v.ld));
            if (!v.ld) check($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
            check($sformatf("v%0d_busy_stall", idx), 32'(stall), 32'd1);
            mem_ack   = 1'b1;
            mem_rdata = v.rdata;
            tick();
            mem_ack = 1'b0;
            check($sformatf("v%0d_ldv", idx), 32'(ld_valid), 32'(v.ld_valid));
            if (v.ld_valid) check($sformatf("v%0d_ld_data", idx), ld_data, v.ld_data);
            check($sformatf("v%0d_done_req", idx), 32'(mem_req), 32'd0);
            check($sformatf("v%0d_done_stall", idx), 32'(stall), 32'd0);
            check($sformatf("v%0d_done_flags", idx), 32'({misalign, acc_err}), 32'd0);
        end
        load_en  = 1'b0;
        store_en = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int req_cycles;
        int guard;

        //            ld    st    f3      addr          rs2           rdata         be       wdata         ldv   ld_data       mis   err
        vecs[0]  = '{1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0000, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0000, 4'b1000, 32'h0,        1'b1, 32'h0000_0080, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_0000, 4'b1100, 32'h0,        1'b1, 32'hFFFF_80FF, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h1234_8765, 4'b0011, 32'h0,        1'b1, 32'h0000_8765, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 4'b0010, 32'h0,        1'b1, 32'h0000_007F, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'hFFFF_0000, 4'b1100, 32'h0,        1'b1, 32'h0000_FFFF, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'hFFFF_FFFF, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'hFFFF_FFFF, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h0000_0200, 32'h0000_BEEF, 32'hFFFF_FFFF, 4'b0011, 32'hBEEF_BEEF, 1'b0, 32'h0,        1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h0000_0300, 32'h5555_5555, 32'h1122_3344, 4'b1111, 32'h0,        1'b1, 32'h1122_3344, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 3'b001, 32'h0000_0203, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 3'b011, 32'h0000_0200, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 3'b111, 32'h0000_0100, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};

        rst_n     = 1'b0;
        load_en   = 1'b1;
        store_en  = 1'b0;
        load_en_t = 1'b0;
        funct3    = 3'b010;
        addr      = 32'h100;
        data_rs2  = 32'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        mem_ack_t = 1'b0;
        tick();
        tick();
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_bus", mem_addr | mem_wdata | 32'(mem_be) | 32'(mem_we), 32'd0);
        check("rst_ld", ld_data, 32'd0);
        check("rst_flags", 32'({ld_valid, misalign, acc_err}), 32'd0);
        load_en = 1'b0;
        rst_n   = 1'b1;
        tick();

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // sh with a slow ack: bus fields must stay put for all five request cycles.
        store_en = 1'b1;
        funct3   = 3'b001;
        addr     = 32'h0000_0202;
        data_rs2 = 32'h1234_ABCD;
        tick();
        for (int c = 0; c < 5; c++) begin
            check($sformatf("sh_req_c%0d", c), 32'(mem_req), 32'd1);
            check($sformatf("sh_we_c%0d", c), 32'(mem_we), 32'd1);
            check($sformatf("sh_be_c%0d", c), 32'(mem_be), 32'hC);
            check($sformatf("sh_wdata_c%0d", c), mem_wdata, 32'hABCD_ABCD);
            check($sformatf("sh_stall_c%0d", c), 32'(stall), 32'd1);
            if (c == 4) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check("sh_done_ldv", 32'(ld_valid), 32'd0);
        check("sh_done_req", 32'(mem_req), 32'd0);
        check("sh_done_stall", 32'(stall), 32'd0);
        store_en = 1'b0;
        tick();

        // TIMEOUT=4 instance: a good load first so the zeroed ld_data is observable.
        load_en_t = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h0000_0400;
        mem_rdata = 32'h55AA_55AA;
        tick();
        check("t_ok_req", 32'(t_mem_req), 32'd1);
        mem_ack_t = 1'b1;
        tick();
        mem_ack_t = 1'b0;
        check("t_ok_ldv", 32'(t_ld_valid), 32'd1);
        check("t_ok_ld", t_ld_data, 32'h55AA_55AA);
        load_en_t = 1'b0;
        tick();
        load_en_t = 1'b1;
        addr      = 32'h0000_0404;
        tick();
        req_cycles = 0;
        guard      = 0;
        while (t_mem_req && guard < 20) begin
            req_cycles++;
            guard++;
            tick();
        end
        check("t_req_cycles", 32'(req_cycles), 32'd4);
        check("t_acc_err", 32'(t_acc_err), 32'd1);
        check("t_ld_zero", t_ld_data, 32'd0);
        check("t_ldv", 32'(t_ld_valid), 32'd0);
        check("t_done_stall", 32'(t_stall), 32'd0);
        load_en_t = 1'b0;
        tick();
        check("t_err_pulse", 32'(t_acc_err), 32'd0);

        // Reset during the second BUSY cycle, then a stray ack while idle.
        load_en = 1'b1;
        funct3  = 3'b010;
        addr    = 32'h0000_0500;
        tick();
        check("rm_busy1_req", 32'(mem_req), 32'd1);
        tick();
        check("rm_busy2_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rm_rst_req", 32'(mem_req), 32'd0);
        check("rm_rst_stall", 32'(stall), 32'd0);
        rst_n     = 1'b1;
        load_en   = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h7777_7777;
        #1;
        check("rm_idle_stall", 32'(stall), 32'd0);
        tick();
        mem_ack = 1'b0;
        check("rm_stray_ldv", 32'(ld_valid), 32'd0);
        check("rm_stray_req", 32'(mem_req), 32'd0);
        tick();
        check("rm_stray_ldv2", 32'(ld_valid), 32'd0);
        run_vec(vecs[0], 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
